// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bus between the core and the load/store unit.
//   req_valid/req_ready   request handshake (core -> LSU)
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I load/store funct3
//   req_addr              byte address
//   req_wdata             store data
//   rsp_valid/rsp_ready   response handshake (LSU -> core)
//   rsp_rdata             extended load data, 0 for stores and errors
//   rsp_err/rsp_err_code  access failed (1 misaligned, 2 access fault, 3 illegal funct3)
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;

    // Core side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit plus data memory for the multicycle RV32I core.
// A little-endian byte-addressed RAM region and a small read-only constant
// table are decoded from addr[31:20]. Each access walks IDLE -> ACCESS -> RESP.
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    dmem_lsu_if.slave request/response bus
module dmem_lsu #(
    parameter int          RAM_BYTES   = 4096,
    parameter logic [11:0] RAM_BASE_HI = 12'h800,
    parameter int          ROM_BYTES   = 12,
    parameter logic [11:0] ROM_BASE_HI = 12'h001
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.slave bus
);

    localparam int          RAM_AW    = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam logic [20:0] RAM_LIMIT = 21'(RAM_BYTES);
    localparam logic [20:0] ROM_LIMIT = 21'(ROM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  code_q;

    logic [7:0]  ram [RAM_BYTES];

    logic              illegal, misaligned, fault, any_err;
    logic              in_ram, in_rom;
    logic [1:0]        code_d;
    logic [20:0]       offset;
    logic [RAM_AW-1:0] ram_idx;
    logic [11:0]       rom_idx;
    logic [7:0]        rd_byte [4];
    logic [31:0]       load_data;

    // Constant table contents; anything past the defined bytes reads as zero.
    function automatic logic [7:0] rom_byte(input logic [11:0] idx);
        case (idx)
            12'd0:   rom_byte = 8'h95;
            12'd1:   rom_byte = 8'h91;
            12'd2:   rom_byte = 8'h71;
            12'd3:   rom_byte = 8'h11;
            12'd4:   rom_byte = 8'h76;
            12'd5:   rom_byte = 8'h29;
            12'd6:   rom_byte = 8'h03;
            12'd7:   rom_byte = 8'h16;
            12'd8:   rom_byte = 8'h26;
            12'd9:   rom_byte = 8'h94;
            12'd10:  rom_byte = 8'h75;
            12'd11:  rom_byte = 8'h11;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    // State register; reset drops any in-flight access or pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = ACCESS;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on the accepting edge so the core may change its
    // bus signals while the access is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (state_q == IDLE && bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Decode and checks on the latched request. Error priority is
    // illegal funct3, then misalignment, then access fault.
    always_comb begin
        offset  = {1'b0, lat_addr[19:0]};
        in_ram  = (lat_addr[31:20] == RAM_BASE_HI) && (offset < RAM_LIMIT);
        in_rom  = (lat_addr[31:20] == ROM_BASE_HI) && (offset < ROM_LIMIT);
        ram_idx = lat_addr[RAM_AW-1:0];
        rom_idx = lat_addr[11:0];

        if (lat_we) illegal = !(lat_f3 == 3'b000 || lat_f3 == 3'b001 || lat_f3 == 3'b010);
        else        illegal = !(lat_f3 == 3'b000 || lat_f3 == 3'b001 || lat_f3 == 3'b010 ||
                                lat_f3 == 3'b100 || lat_f3 == 3'b101);

        misaligned = ((lat_f3[1:0] == 2'b01) && lat_addr[0]) ||
                     ((lat_f3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
        fault      = !(in_ram || in_rom) || (lat_we && in_rom);

        code_d = 2'd0;
        if (illegal)         code_d = 2'd3;
        else if (misaligned) code_d = 2'd1;
        else if (fault)      code_d = 2'd2;
        any_err = (code_d != 2'd0);
    end

    // Gather the four byte lanes from whichever region the address hits.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (in_rom) rd_byte[k] = rom_byte(rom_idx + 12'(k));
            else        rd_byte[k] = ram[ram_idx + RAM_AW'(k)];
        end
    end

    // Width selection and sign/zero extension.
    always_comb begin
        load_data = 32'd0;
        case (lat_f3)
            3'b000:  load_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
            3'b001:  load_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            3'b010:  load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            3'b100:  load_data = {24'd0, rd_byte[0]};
            3'b101:  load_data = {16'd0, rd_byte[1], rd_byte[0]};
            default: load_data = 32'd0;
        endcase
    end

    // Response registers are loaded in ACCESS and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (any_err || lat_we) ? 32'd0 : load_data;
            err_q   <= any_err;
            code_q  <= code_d;
        end
    end

    // RAM write port. Gated by state, so a reset during ACCESS (which forces
    // IDLE asynchronously) suppresses the write.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && lat_we && !any_err) begin
            ram[ram_idx] <= lat_wdata[7:0];
            if (lat_f3[1:0] != 2'b00) begin
                ram[ram_idx + RAM_AW'(1)] <= lat_wdata[15:8];
            end
            if (lat_f3[1:0] == 2'b10) begin
                ram[ram_idx + RAM_AW'(2)] <= lat_wdata[23:16];
                ram[ram_idx + RAM_AW'(3)] <= lat_wdata[31:24];
            end
        end
    end

    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_err      = err_q;
    assign bus.rsp_err_code = code_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table plus hand-written back-pressure and
// reset sequences for dmem_lsu.
module tb_dmem_lsu;

    logic clk;
    logic rst_n;

    dmem_lsu_if bus ();

    dmem_lsu #(
        .RAM_BYTES  (4096),
        .RAM_BASE_HI(12'h800),
        .ROM_BYTES  (12),
        .ROM_BASE_HI(12'h001)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // 10 time-unit clock; inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    int assert_count = 0;
    int fail_count   = 0;

    function automatic void add_vec(input string name, input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp_rdata, input logic [1:0] exp_code);
        vec_t v;
        v.name      = name;
        v.we        = we;
        v.f3        = f3;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err   = (exp_code != 2'd0);
        v.exp_code  = exp_code;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge where
    // rsp_valid is first seen, with the number of negedges since acceptance.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output logic [1:0] code, output int lat);
        int guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) lat = 99;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        code  = bus.rsp_err_code;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  cd;
        int          lat;

        // Reads from the constant table
        add_vec("lw_rom0",     1'b0, 3'b010, 32'h0010_0000, 32'h0,         32'h1171_9195, 2'd0);
        add_vec("lw_rom8",     1'b0, 3'b010, 32'h0010_0008, 32'h0,         32'h1175_9426, 2'd0);
        add_vec("lb_rom0",     1'b0, 3'b000, 32'h0010_0000, 32'h0,         32'hFFFF_FF95, 2'd0);
        add_vec("lbu_rom0",    1'b0, 3'b100, 32'h0010_0000, 32'h0,         32'h0000_0095, 2'd0);
        add_vec("lh_rom2",     1'b0, 3'b001, 32'h0010_0002, 32'h0,         32'h0000_1171, 2'd0);
        add_vec("lhu_rom6",    1'b0, 3'b101, 32'h0010_0006, 32'h0,         32'h0000_1603, 2'd0);
        // RAM store/load sequence
        add_vec("sw_ram0",     1'b1, 3'b010, 32'h8000_0000, 32'h0000_0000, 32'h0,         2'd0);
        add_vec("sh_ram2",     1'b1, 3'b001, 32'h8000_0002, 32'hABCD_1234, 32'h0,         2'd0);
        add_vec("lw_ram0_a",   1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h1234_0000, 2'd0);
        add_vec("sb_ram1",     1'b1, 3'b000, 32'h8000_0001, 32'h0000_00FF, 32'h0,         2'd0);
        add_vec("lw_ram0_b",   1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h1234_FF00, 2'd0);
        add_vec("lb_ram1",     1'b0, 3'b000, 32'h8000_0001, 32'h0,         32'hFFFF_FFFF, 2'd0);
        add_vec("sh_ram4",     1'b1, 3'b001, 32'h8000_0004, 32'h5555_8001, 32'h0,         2'd0);
        add_vec("lh_ram4",     1'b0, 3'b001, 32'h8000_0004, 32'h0,         32'hFFFF_8001, 2'd0);
        add_vec("lhu_ram4",    1'b0, 3'b101, 32'h8000_0004, 32'h0,         32'h0000_8001, 2'd0);
        add_vec("sw_ram20",    1'b1, 3'b010, 32'h8000_0020, 32'h1111_1111, 32'h0,         2'd0);
        // Errors and priority
        add_vec("lw_misal",    1'b0, 3'b010, 32'h8000_0001, 32'h0,         32'h0,         2'd1);
        add_vec("sw_misal",    1'b1, 3'b010, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0,         2'd1);
        add_vec("lw_nowrite",  1'b0, 3'b010, 32'h8000_0000, 32'h0,         32'h1234_FF00, 2'd0);
        add_vec("sw_rom",      1'b1, 3'b010, 32'h0010_0000, 32'h1234_5678, 32'h0,         2'd2);
        add_vec("lw_rom_kept", 1'b0, 3'b010, 32'h0010_0000, 32'h0,         32'h1171_9195, 2'd0);
        add_vec("lw_ram_end",  1'b0, 3'b010, 32'h8000_1000, 32'h0,         32'h0,         2'd2);
        add_vec("lw_rom_end",  1'b0, 3'b010, 32'h0010_000C, 32'h0,         32'h0,         2'd2);
        add_vec("lw_unmapped", 1'b0, 3'b010, 32'h4000_0000, 32'h0,         32'h0,         2'd2);
        add_vec("ld_f3_011",   1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         2'd3);
        add_vec("st_f3_100",   1'b1, 3'b100, 32'h8000_0000, 32'h0,         32'h0,         2'd3);
        add_vec("st_prio3",    1'b1, 3'b011, 32'h0010_0001, 32'h0,         32'h0,         2'd3);
        add_vec("sh_prio1",    1'b1, 3'b001, 32'h0010_0001, 32'h0,         32'h0,         2'd1);

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;
        rst_n          = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready),    32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid),    32'd0);
        checkOutput("rst_rdata",     bus.rsp_rdata,         32'd0);
        checkOutput("rst_err",       32'(bus.rsp_err),      32'd0);
        checkOutput("rst_code",      32'(bus.rsp_err_code), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, cd, lat);
            checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
            checkOutput({vecs[i].name, "_rdata"},   rd,       vecs[i].exp_rdata);
            checkOutput({vecs[i].name, "_err"},     32'(er),  32'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_code"},    32'(cd),  32'(vecs[i].exp_code));
            @(negedge clk);
        end

        // Back-pressure: response held for three cycles, a stray store
        // request during that time must be ignored.
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h0010_0004, 32'h0, rd, er, cd, lat);
        checkOutput("bp_rdata", rd, 32'h1603_2976);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h8000_0020;
        bus.req_wdata  = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_rdata_hold", bus.rsp_rdata, 32'h1603_2976);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        checkOutput("bp_no_phantom", 32'(bus.rsp_valid), 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h8000_0020, 32'h0, rd, er, cd, lat);
        checkOutput("bp_store_ignored", rd, 32'h1111_1111);
        @(negedge clk);

        // Reset during ACCESS of a store: write suppressed, outputs cleared.
        applyStimulus(1'b1, 3'b010, 32'h8000_0010, 32'hA5A5_A5A5, rd, er, cd, lat);
        @(negedge clk);
        applyStimulus(1'b0, 3'b010, 32'h8000_0010, 32'h0, rd, er, cd, lat);
        checkOutput("pre_rst_lw", rd, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h8000_0010;
        bus.req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_acc_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_acc_rdata",     bus.rsp_rdata,      32'd0);
        checkOutput("rst_acc_err",       32'(bus.rsp_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'b010, 32'h8000_0010, 32'h0, rd, er, cd, lat);
        checkOutput("rst_acc_no_write", rd, 32'hA5A5_A5A5);
        @(negedge clk);

        // Reset during RESP: the pending response is discarded.
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h0010_0000, 32'h0, rd, er, cd, lat);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_resp_rdata", bus.rsp_rdata,      32'd0);
        checkOutput("rst_resp_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
